// File: rtl/rr_arbiter_138.sv
// Eight-way round-robin arbiter with an active-low one-hot grant, per-grant hold limit
// and a mandatory release cycle between grants.
module rr_arbiter_138 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant_n,
  output logic [2:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_W = 8'(MAX_HOLD);

  state_t     state_reg;
  logic [2:0] ptr_reg;
  logic [7:0] hold_reg;

  logic [7:0] rot;
  logic [2:0] offset;
  logic [2:0] pick_idx;
  logic [7:0] hold_inc;
  logic       hold_hit;
  logic       grant_exit;

  // rot[i] is the request that sits i places above the search pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot[gi] = req[3'(ptr_reg + 3'(gi))];
    end
  endgenerate

  always_comb begin
    offset = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) offset = 3'(i);
    end
  end

  assign pick_idx   = ptr_reg + offset;
  assign hold_inc   = (hold_reg == 8'hFF) ? hold_reg : hold_reg + 8'd1;
  assign hold_hit   = (hold_inc >= MAX_HOLD_W);
  assign grant_exit = done | ~req[grant_idx] | ~en | hold_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_n   <= 8'hFF;
      grant_idx <= 3'd0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      ptr_reg   <= 3'd0;
      hold_reg  <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          timeout <= 1'b0;
          if (en && (req != 8'd0)) begin
            state_reg <= GRANT;
            grant_n   <= ~(8'd1 << pick_idx);
            grant_idx <= pick_idx;
            busy      <= 1'b1;
            hold_reg  <= 8'd0;
          end
        end
        GRANT: begin
          hold_reg <= hold_inc;
          if (grant_exit) begin
            state_reg <= RELEASE;
            grant_n   <= 8'hFF;
            busy      <= 1'b0;
            // A done pulse in the limit cycle counts as a clean release.
            timeout   <= hold_hit & ~done;
            ptr_reg   <= grant_idx + 3'd1;
          end
        end
        RELEASE: begin
          state_reg <= IDLE;
          timeout   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          grant_n   <= 8'hFF;
          busy      <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_138.sv
// Bench for rr_arbiter_138: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_rr_arbiter_138;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant_n;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  // model: owner -1 means nobody holds the resource
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_cool  = 0;
  bit m_to    = 1'b0;

  rr_arbiter_138 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .grant_n(grant_n), .grant_idx(grant_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic void model_step();
    bit found;
    if (reset) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_cool = 0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      if (m_held < 255) m_held++;
      if (done || !req[m_owner] || !en || m_held >= MH) begin
        m_to    = (m_held >= MH) && !done;
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_to = 1'b0;
      end
    end else if (m_cool != 0) begin
      m_cool = 0;
      m_to   = 1'b0;
    end else begin
      m_to  = 1'b0;
      found = 1'b0;
      if (en && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (!found && req[(m_ptr + k) % 8]) begin
            found   = 1'b1;
            m_owner = (m_ptr + k) % 8;
            m_last  = m_owner;
            m_held  = 0;
          end
        end
      end
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] gn;
    gn = (m_owner < 0) ? 8'hFF : ~(8'd1 << m_owner);
    return {gn, 3'(m_last), (m_owner >= 0), m_to};
  endfunction

  task automatic clock_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    clock_cycle();
    tests++;
    if ({grant_n, grant_idx, busy, timeout} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", {grant_n, grant_idx, busy, timeout}, {8'hFF, 3'd0, 1'b0, 1'b0});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] want [4] = '{8'hFE, 8'hFF, 8'hFF, 8'hFE};
    reset = 1'b1; clock_cycle(); reset = 1'b0;
    req = 8'h01; en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      done = (c == 1);
      clock_cycle();
      tests++;
      if ({grant_n, grant_idx, busy, timeout} !== exp_vec() || grant_n !== want[c]) begin
        fails++;
        $display("FAIL single c%0d: got %h want %h (grant_n want %h)", c, {grant_n, grant_idx, busy, timeout}, exp_vec(), want[c]);
      end
      $display("[TB] single c%0d grant_n=%h idx=%0d busy=%b", c, grant_n, grant_idx, busy);
    end
    done = 1'b0;
  endtask

  task automatic test_rotation();
    int gap;
    bit got;
    reset = 1'b1; clock_cycle(); reset = 1'b0;
    req = 8'hFF; en = 1'b1; done = 1'b0;
    for (int n = 0; n < 9; n++) begin
      gap = 0; got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        clock_cycle();
        tests++;
        if ({grant_n, grant_idx, busy, timeout} !== exp_vec()) begin
          fails++;
          $display("FAIL rotation_cycle: got %h want %h", {grant_n, grant_idx, busy, timeout}, exp_vec());
        end
        if (busy === 1'b1) got = 1'b1; else gap++;
      end
      tests++;
      if (!got || grant_idx !== 3'(n % 8) || (n > 0 && gap < 1)) begin
        fails++;
        $display("FAIL rotation_grant%0d: got idx %0d busy %b gap %0d want idx %0d", n, grant_idx, busy, gap, n % 8);
      end
      $display("[TB] rotation grant %0d idx=%0d gap=%0d", n, grant_idx, gap);
      done = 1'b1; clock_cycle(); done = 1'b0;
      tests++;
      if ({grant_n, grant_idx, busy, timeout} !== exp_vec()) begin
        fails++;
        $display("FAIL rotation_release: got %h want %h", {grant_n, grant_idx, busy, timeout}, exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    int run, best, pulses;
    reset = 1'b1; clock_cycle(); reset = 1'b0;
    req = 8'h10; en = 1'b1; done = 1'b0;
    run = 0; best = 0; pulses = 0;
    for (int c = 0; c < 12; c++) begin
      clock_cycle();
      tests++;
      if ({grant_n, grant_idx, busy, timeout} !== exp_vec()) begin
        fails++;
        $display("FAIL timeout_cycle%0d: got %h want %h", c, {grant_n, grant_idx, busy, timeout}, exp_vec());
      end
      if (grant_n === 8'hEF) run++; else run = 0;
      if (run > best) best = run;
      if (timeout === 1'b1) pulses++;
      if (c == 6) begin
        tests++;
        if (grant_n !== 8'hEF || grant_idx !== 3'd4) begin
          fails++;
          $display("FAIL timeout_regrant: got %h/%0d want ef/4", grant_n, grant_idx);
        end
      end
    end
    tests++;
    if (best != MH || pulses != 2) begin
      fails++;
      $display("FAIL timeout_hold: got run %0d pulses %0d want run %0d pulses 2", best, pulses, MH);
    end
    $display("[TB] timeout hold run=%0d pulses=%0d", best, pulses);
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; clock_cycle(); reset = 1'b0;
    req = 8'h80; en = 1'b1; done = 1'b0;
    clock_cycle(); clock_cycle();
    tests++;
    if (grant_n !== 8'h7F || grant_idx !== 3'd7 || busy !== 1'b1) begin
      fails++;
      $display("FAIL resetmid_grant: got %h/%0d want 7f/7", grant_n, grant_idx);
    end
    reset = 1'b1; clock_cycle(); reset = 1'b0;
    tests++;
    if ({grant_n, grant_idx, busy, timeout} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL resetmid_clear: got %h want %h", {grant_n, grant_idx, busy, timeout}, {8'hFF, 3'd0, 1'b0, 1'b0});
    end
    clock_cycle();
    tests++;
    if (grant_n !== 8'h7F || grant_idx !== 3'd7 || {grant_n, grant_idx, busy, timeout} !== exp_vec()) begin
      fails++;
      $display("FAIL resetmid_regrant: got %h want %h", {grant_n, grant_idx, busy, timeout}, exp_vec());
    end
    $display("[TB] reset mid-grant then regrant idx=%0d", grant_idx);
  endtask

  task automatic test_enable();
    bit got;
    reset = 1'b1; clock_cycle(); reset = 1'b0;
    req = 8'h0C; en = 1'b0; done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      clock_cycle();
      tests++;
      if (grant_n !== 8'hFF || busy !== 1'b0) begin
        fails++;
        $display("FAIL enable_off: got %h want ff", grant_n);
      end
    end
    en = 1'b1; clock_cycle();
    tests++;
    if (grant_n !== 8'hFB || grant_idx !== 3'd2) begin
      fails++;
      $display("FAIL enable_grant2: got %h/%0d want fb/2", grant_n, grant_idx);
    end
    clock_cycle();
    en = 1'b0; clock_cycle();
    tests++;
    if (grant_n !== 8'hFF || busy !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL enable_drop: got %h busy %b want ff busy 0", grant_n, busy);
    end
    en = 1'b1; got = 1'b0;
    for (int w = 0; w < 4 && !got; w++) begin
      clock_cycle();
      tests++;
      if ({grant_n, grant_idx, busy, timeout} !== exp_vec()) begin
        fails++;
        $display("FAIL enable_cycle: got %h want %h", {grant_n, grant_idx, busy, timeout}, exp_vec());
      end
      if (busy === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got || grant_n !== 8'hF7 || grant_idx !== 3'd3) begin
      fails++;
      $display("FAIL enable_grant3: got %h/%0d want f7/3", grant_n, grant_idx);
    end
    $display("[TB] enable sequence regrant idx=%0d", grant_idx);
  endtask

  task automatic test_done_timeout();
    reset = 1'b1; clock_cycle(); reset = 1'b0;
    req = 8'h01; en = 1'b1; done = 1'b0;
    for (int c = 0; c < MH; c++) clock_cycle();
    tests++;
    if (busy !== 1'b1 || grant_n !== 8'hFE) begin
      fails++;
      $display("FAIL coincide_held: got %h busy %b want fe busy 1", grant_n, busy);
    end
    done = 1'b1; clock_cycle(); done = 1'b0;
    tests++;
    if (busy !== 1'b0 || timeout !== 1'b0 || grant_n !== 8'hFF) begin
      fails++;
      $display("FAIL coincide_release: got %h busy %b timeout %b want ff 0 0", grant_n, busy, timeout);
    end
    clock_cycle(); clock_cycle();
    tests++;
    if (grant_n !== 8'hFE || {grant_n, grant_idx, busy, timeout} !== exp_vec()) begin
      fails++;
      $display("FAIL coincide_regrant: got %h want %h", {grant_n, grant_idx, busy, timeout}, exp_vec());
    end
    req = 8'h00; clock_cycle();
    tests++;
    if (busy !== 1'b0 || timeout !== 1'b0 || grant_n !== 8'hFF) begin
      fails++;
      $display("FAIL reqdrop_release: got %h busy %b want ff 0", grant_n, busy);
    end
    $display("[TB] done/limit coincidence and req drop checked");
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    reset = 1'b1; clock_cycle(); reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req   = 8'($urandom);
      en    = ($urandom_range(0, 9) != 0);
      done  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0 && m_owner >= 0) req[m_owner] = 1'b1;
      clock_cycle();
      tests++;
      if ({grant_n, grant_idx, busy, timeout} !== exp_vec()) begin
        fails++; bad++;
        $display("FAIL random_c%0d: got %h want %h", c, {grant_n, grant_idx, busy, timeout}, exp_vec());
      end
    end
    reset = 1'b0; done = 1'b0;
    $display("[TB] random 400 cycles, %0d mismatching", bad);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_done_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_138.md
RR_ARBITER_138 -- requirements
Module: rr_arbiter_138

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 16, giving the maximum cycles a grant is held before forced release (legal range 1..255).
REQ-002 SHALL provide port clk, input, 1, the single rising-edge clock for all state.
REQ-003 SHALL provide port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL provide port en, input, 1, the global arbitration enable (same role as decoder G1).
REQ-005 SHALL provide port req, input, 8, with bit k high meaning requester k wants the shared resource.
REQ-006 SHALL provide port done, input, 1, a single-cycle pulse from the current grantee that releases the grant.
REQ-007 SHALL provide port grant_n, output, 8, an active-low one-hot grant: bit k low means requester k owns the resource; all ones means none.
REQ-008 SHALL provide port grant_idx, output, 3, the binary index of the current or last grantee.
REQ-009 SHALL provide port busy, output, 1, high while any grant is active.
REQ-010 SHALL provide port timeout, output, 1, a one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-011 SHALL implement states IDLE, GRANT and RELEASE, with all outputs registered.
REQ-012 In IDLE with en=1 and req!=0, SHALL select the first set req bit searching upward from ptr with wrap 7->0, then enter GRANT on the next edge.
REQ-013 Grant latency SHALL be exactly one cycle: req sampled at edge N means grant_n[k]=0, grant_idx=k and busy=1 after edge N.
REQ-014 In GRANT, grant_n SHALL have exactly one bit low, matching grant_idx; other requesters' req changes SHALL be ignored.
REQ-015 GRANT SHALL exit to RELEASE on the first of: done=1, req[grant_idx]=0, en=0, or hold counter reaching MAX_HOLD.
REQ-016 The hold counter SHALL clear on entry to GRANT, increment each GRANT cycle, and saturate (no wrap).
REQ-017 Timeout SHALL pulse high for one cycle only when the exit cause is MAX_HOLD and done=0 in that cycle; if done and timeout coincide, done takes priority and timeout stays 0.
REQ-018 On GRANT exit, SHALL set ptr = grant_idx+1 mod 8, so index 7 wraps to 0.
REQ-019 RELEASE SHALL last exactly one cycle with grant_n=8'hFF and busy=0, then go to IDLE; this gives a mandatory one-cycle gap between grants.
REQ-020 In IDLE with en=0 or req=0, SHALL hold grant_n=8'hFF, busy=0, and leave ptr and grant_idx unchanged.
REQ-021 done asserted outside GRANT SHALL be ignored.

Reset
REQ-022 reset=1 SHALL force, on that edge: state=IDLE, grant_n=8'hFF, grant_idx=0, busy=0, timeout=0, ptr=0, hold counter=0.
REQ-023 reset SHALL override all other inputs, including mid-GRANT, with no RELEASE cycle and no timeout pulse.

Verification
REQ-024 Reset then req=8'h01, en=1 -> one cycle later grant_n=8'hFE, grant_idx=0, busy=1; done pulse -> next cycle grant_n=8'hFF (RELEASE), then IDLE, and with req still 8'h01 a re-grant to 0.
REQ-025 req=8'hFF held, done pulsed one cycle after each grant -> grant_idx sequence 0,1,2,...,7,0 with a one-cycle all-ones gap between each.
REQ-026 MAX_HOLD=4, req=8'h10, no done -> grant_n=8'hEF for 4 cycles, timeout pulse for one cycle, RELEASE, then re-grant to 4 (only requester, ptr=5 wraps search to 4).
REQ-027 Grant to 7 active, reset=1 mid-GRANT -> next cycle grant_n=8'hFF, grant_idx=0, busy=0, timeout=0; then req=8'h80 -> grant to 7.
REQ-028 en=0 with req=8'h0C -> grant_n stays 8'hFF; en=1 -> grant to 2; en dropped mid-GRANT -> RELEASE next edge; re-enable -> grant to 3.
REQ-029 done and MAX_HOLD limit in the same cycle -> RELEASE with timeout=0; req of the grantee deasserted -> RELEASE next edge.
